// File: rtl/diffeq_datapath.sv
// diffeq_datapath: fixed-point datapath for one Euler step of y'' + 3xy' + 3y = 0,
// driven by the controller's phase code and operand-load strobes.
// Latency: each compute phase performs its work in its step0/step1 cycle;
// compute_done rises in the phase's final step.
// Backpressure: none. The controller holds the phase code until it sees compute_done.
// A phase held longer saturates the step counter, so no work repeats.
// Ports:
//   clk, reset (async, active-high)
//   state: phase code
//   din + load_*: operand loads (IDLE/READ only)
//   compute_done, continue_while: handshakes back to the controller
//   x_out/u_out/y_out: committed state
//   iter_count: completed iterations
// Optional: define DIFFEQ_SAT_EN to saturate every add/sub/3*v/fx() result
// instead of wrapping.
module diffeq_datapath #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [WIDTH-1:0]  din,
  input  logic              load_x,
  input  logic              load_dx,
  input  logic              load_a,
  input  logic              load_u,
  input  logic              load_y,
  output logic              compute_done,
  output logic              continue_while,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  u_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_READ = 3'b001;
  localparam logic [2:0] ST_C1   = 3'b010;
  localparam logic [2:0] ST_C2   = 3'b011;
  localparam logic [2:0] ST_C3   = 3'b100;
  localparam logic [2:0] ST_C4   = 3'b101;

  localparam int DW = 2 * WIDTH;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [DW-1:0]    wide_t;

  localparam wide_t MAX_W = wide_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam wide_t MIN_W = -MAX_W - 1;

  // Reduce a wide intermediate to WIDTH bits: clamp or plain truncation.
  function automatic word_t clip(input wide_t v);
`ifdef DIFFEQ_SAT_EN
    if (v > MAX_W)      clip = MAX_W[WIDTH-1:0];
    else if (v < MIN_W) clip = MIN_W[WIDTH-1:0];
    else                clip = v[WIDTH-1:0];
`else
    clip = v[WIDTH-1:0];
`endif
  endfunction

  function automatic wide_t ext(input word_t v);
    ext = wide_t'(v);
  endfunction

  function automatic word_t add_w(input word_t p, input word_t q);
    add_w = clip(ext(p) + ext(q));
  endfunction

  function automatic word_t sub_w(input word_t p, input word_t q);
    sub_w = clip(ext(p) - ext(q));
  endfunction

  function automatic word_t triple(input word_t v);
    triple = clip((ext(v) <<< 1) + ext(v));
  endfunction

  word_t x, dx, a, u, y;
  word_t t1, t2, t3, t4;
  word_t x_n, u_n, y_n;

  logic [2:0] prev_state;
  logic [1:0] cnt_q;
  logic [1:0] step;
  logic [1:0] last_step;
  logic       entry;
  logic       in_phase;
  logic       load_ok;
  logic       any_load;

  // Single shared multiplier.
  word_t mul_a, mul_b, fx_res, y3;
  wide_t prod;

  assign entry     = (state != prev_state);
  assign step      = entry ? 2'd0 : cnt_q;
  assign in_phase  = (state == ST_C1) || (state == ST_C2) ||
                     (state == ST_C3) || (state == ST_C4);
  assign last_step = (state == ST_C2) ? 2'd2 : 2'd1;

  // Combinational so the pulse can never leak into a following state.
  assign compute_done = in_phase && (step == last_step);

  assign load_ok  = (state == ST_IDLE) || (state == ST_READ);
  assign any_load = load_x | load_dx | load_a | load_u | load_y;

  assign y3 = triple(y);

  always_comb begin
    mul_a = u;
    mul_b = dx;
    if (state == ST_C2) begin
      if (step == 2'd0) begin
        mul_a = t1;
        mul_b = t2;
      end else begin
        mul_a = y3;
        mul_b = dx;
      end
    end
  end

  assign prod   = ext(mul_a) * ext(mul_b);
  assign fx_res = clip(prod >>> FRAC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state     <= ST_IDLE;
      cnt_q          <= 2'd0;
      x              <= '0;
      dx             <= '0;
      a              <= '0;
      u              <= '0;
      y              <= '0;
      t1             <= '0;
      t2             <= '0;
      t3             <= '0;
      t4             <= '0;
      x_n            <= '0;
      u_n            <= '0;
      y_n            <= '0;
      iter_count     <= '0;
      continue_while <= 1'b1;
    end else begin
      prev_state <= state;
      // Counter reads 1 in the cycle after entry and saturates at last_step + 1.
      if (entry)                   cnt_q <= 2'd1;
      else if (cnt_q <= last_step) cnt_q <= cnt_q + 2'd1;

      if (load_ok && any_load) begin
        if (load_x)       x  <= din;
        else if (load_dx) dx <= din;
        else if (load_a)  a  <= din;
        else if (load_u)  u  <= din;
        else              y  <= din;
        continue_while <= 1'b1;
        iter_count     <= '0;
      end

      if (step == 2'd0) begin
        case (state)
          ST_C1: begin
            t1 <= fx_res;
            t2 <= triple(x);
          end
          ST_C2: t3 <= fx_res;
          ST_C3: begin
            u_n <= sub_w(sub_w(u, t3), t4);
            y_n <= add_w(y, t1);
            x_n <= add_w(x, dx);
          end
          ST_C4: begin
            x              <= x_n;
            u              <= u_n;
            y              <= y_n;
            iter_count     <= iter_count + ITER_W'(1);
            // Sticky low: only reset or a load re-arms the loop.
            continue_while <= continue_while & (x_n < a);
          end
          default: ;
        endcase
      end

      if ((state == ST_C2) && (step == 2'd1)) t4 <= fx_res;
    end
  end

  assign x_out = x;
  assign u_out = u;
  assign y_out = y;

endmodule

// File: tb/tb_diffeq_datapath.sv
module tb_diffeq_datapath;
  localparam int WIDTH  = 16;
  localparam int FRAC   = 8;
  localparam int ITER_W = 8;

  localparam logic [2:0] S_IDLE = 3'b000, S_READ = 3'b001, S_C1 = 3'b010,
                         S_C2 = 3'b011, S_C3 = 3'b100, S_C4 = 3'b101,
                         S_DONE = 3'b110, S_UNDEF = 3'b111;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        state;
  logic [WIDTH-1:0]  din;
  logic              load_x, load_dx, load_a, load_u, load_y;
  logic              compute_done, continue_while;
  logic [WIDTH-1:0]  x_out, u_out, y_out;
  logic [ITER_W-1:0] iter_count;

  diffeq_datapath #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk(clk), .reset(reset), .state(state), .din(din),
    .load_x(load_x), .load_dx(load_dx), .load_a(load_a), .load_u(load_u), .load_y(load_y),
    .compute_done(compute_done), .continue_while(continue_while),
    .x_out(x_out), .u_out(u_out), .y_out(y_out), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (signed integers).
  longint m_x, m_dx, m_a, m_u, m_y;
  longint p_x, p_u, p_y;
  int     m_iter;
  bit     m_cw;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint lim(input longint v);
    longint m;
`ifdef DIFFEQ_SAT_EN
    m = v;
    if (v > 32767)  m = 32767;
    if (v < -32768) m = -32768;
`else
    m = v & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
`endif
    return m;
  endfunction

  function automatic longint fxm(input longint p, input longint q);
    return lim((p * q) >>> FRAC);
  endfunction

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // One Euler iteration, straight from the equations.
  task automatic model_step();
    longint t1, t2, t3, t4, xn, un, yn;
    t1 = fxm(m_u, m_dx);
    t2 = lim(3 * m_x);
    t3 = fxm(t1, t2);
    t4 = fxm(lim(3 * m_y), m_dx);
    un = lim(lim(m_u - t3) - t4);
    yn = lim(m_y + t1);
    xn = lim(m_x + m_dx);
    m_cw   = m_cw && (xn < m_a);
    m_x    = xn;
    m_u    = un;
    m_y    = yn;
    m_iter = (m_iter + 1) % 256;
  endtask

  task automatic model_reset();
    m_x = 0; m_dx = 0; m_a = 0; m_u = 0; m_y = 0; m_iter = 0; m_cw = 1'b1;
  endtask

  // mask = {x, dx, a, u, y}
  task automatic do_load(input logic [4:0] mask, input logic [15:0] val);
    state = S_READ;
    din = val;
    {load_x, load_dx, load_a, load_u, load_y} = mask;
    @(negedge clk);
    @(posedge clk); #1;
    {load_x, load_dx, load_a, load_u, load_y} = 5'b0;
    if (mask[4])      m_x  = sx(val);
    else if (mask[3]) m_dx = sx(val);
    else if (mask[2]) m_a  = sx(val);
    else if (mask[1]) m_u  = sx(val);
    else if (mask[0]) m_y  = sx(val);
    if (mask != 5'b0) begin
      m_cw = 1'b1;
      m_iter = 0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, sx(x_out), m_x);
    chk({tag, "_u"}, sx(u_out), m_u);
    chk({tag, "_y"}, sx(y_out), m_y);
    chk({tag, "_iter"}, longint'(iter_count), longint'(m_iter));
    chk({tag, "_cw"}, longint'(continue_while), longint'(m_cw));
  endtask

  task automatic run_phase(input logic [2:0] code, input int hold, input int last, input bit inj);
    for (int i = 0; i < hold; i++) begin
      state = code;
      if (inj && i == 3) begin
        load_x = 1'b1;
        din = 16'h1234;
      end
      @(negedge clk);
      chk($sformatf("done_p%0d_c%0d", code, i), longint'(compute_done), longint'(i == last));
      if (code == S_C4 && i == 0) chk("held_x", sx(x_out), p_x);
      if (code == S_C4 && i == 1) check_state("pass");
      @(posedge clk); #1;
      load_x = 1'b0;
    end
  endtask

  task automatic do_pass(input int h1, input int h2, input int h3, input int h4, input bit inj);
    p_x = m_x; p_u = m_u; p_y = m_y;
    model_step();
    run_phase(S_C1, h1, 1, inj);
    run_phase(S_C2, h2, 2, 1'b0);
    run_phase(S_C3, h3, 1, 1'b0);
    run_phase(S_C4, h4, 1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    state = S_IDLE;
    din = '0;
    {load_x, load_dx, load_a, load_u, load_y} = 5'b0;
    model_reset();
    #12;
    check_state("rst0");
    chk("rst0_done", longint'(compute_done), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of C2 while done is high.
    do_load(5'b10000, 16'h0011);
    do_load(5'b01000, 16'h0022);
    do_load(5'b00010, 16'h0033);
    do_load(5'b00001, 16'h0044);
    run_phase(S_C1, 2, 1, 1'b0);
    state = S_C2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("c2_done_pre_rst", longint'(compute_done), 1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_done", longint'(compute_done), 0);
    check_state("midrst");
    state = S_IDLE;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Directed two-pass example.
    do_load(5'b10000, 16'h0000);
    do_load(5'b01000, 16'h0020);
    do_load(5'b00100, 16'h0040);
    do_load(5'b00010, 16'h0100);
    do_load(5'b00001, 16'h0100);
    do_pass(2, 3, 2, 2, 1'b0);
    chk("p1_x", sx(x_out), 32'h20);
    chk("p1_u", sx(u_out), 32'hA0);
    chk("p1_y", sx(y_out), 32'h120);
    chk("p1_iter", longint'(iter_count), 1);
    chk("p1_cw", longint'(continue_while), 1);
    do_pass(2, 3, 2, 2, 1'b0);
    chk("p2_x", sx(x_out), 32'h40);
    chk("p2_u", sx(u_out), 32'h2D);
    chk("p2_y", sx(y_out), 32'h134);
    chk("p2_iter", longint'(iter_count), 2);
    chk("p2_cw", longint'(continue_while), 0);

    // Simultaneous strobes: x wins, continue re-armed.
    do_load(5'b10010, 16'h0055);
    chk("prio_x", sx(x_out), 32'h55);
    chk("prio_u", sx(u_out), 32'h2D);
    chk("prio_cw", longint'(continue_while), 1);
    chk("prio_iter", longint'(iter_count), 0);

    // Long C1 hold with an ignored load_x.
    do_pass(6, 3, 2, 2, 1'b1);

    // DONE and undefined codes: nothing moves.
    state = S_DONE;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) state = S_UNDEF;
      @(negedge clk);
      chk("idle_done", longint'(compute_done), 0);
      check_state("hold");
      @(posedge clk); #1;
    end

    // Overflow behaviour of y + t1.
    do_load(5'b00010, 16'h7F00);
    do_load(5'b00001, 16'h7F00);
    do_load(5'b01000, 16'h0100);
    do_load(5'b10000, 16'h0000);
    do_load(5'b00100, 16'h0100);
    do_pass(2, 3, 2, 2, 1'b0);
`ifdef DIFFEQ_SAT_EN
    chk("sat_y", longint'(y_out), 32'h7FFF);
`else
    chk("sat_y", longint'(y_out), 32'hFE00);
`endif

    // Randomized loads and passes.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 5; k++)
        do_load(5'($urandom_range(1, 31)), 16'($urandom));
      for (int p = 0; p < int'($urandom_range(1, 3)); p++)
        do_pass(int'($urandom_range(2, 4)), int'($urandom_range(3, 5)),
                int'($urandom_range(2, 4)), int'($urandom_range(2, 4)), 1'b0);
      state = S_IDLE;
      @(negedge clk);
      check_state("rnd");
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diffeq_datapath.md
Name: diffeq_datapath

Overview:
- Datapath stage directly downstream of the diffeq sequencing controller.
- Consumes the controller's operand-load strobes and its registered 3-bit phase code. Runs one Euler iteration of y'' + 3xy' + 3y = 0 per COMPUTE_1..COMPUTE_4 pass.
- Returns the compute_done and continue_while handshakes to the controller.
- Signed fixed point; a single shared multiplier performs at most one multiply per cycle.

Parameters:
- WIDTH, 16, bit width of all operand/result registers (signed two's complement).
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC).
- ITER_W, 8, width of iteration counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- state  in  3  phase code from controller (000 IDLE, 001 READ, 010 C1, 011 C2, 100 C3, 101 C4, 110 DONE)
- din  in  WIDTH  operand load bus
- load_x, load_dx, load_a, load_u, load_y  in  1 each  load strobes
- compute_done  out  1  one-cycle phase-complete pulse
- continue_while  out  1  1 while x < a
- x_out, u_out, y_out  out  WIDTH  committed state registers
- iter_count  out  ITER_W  completed iterations

Behaviour:
- Reset (async): x, dx, a, u, y, temporaries and iter_count = 0; compute_done = 0; continue_while = 1.
- Loads:
  - Honoured only when state is 000 or 001; ignored otherwise.
  - Priority when several strobes are high: x > dx > a > u > y.
  - An honoured load writes din to the selected register, sets continue_while = 1 and clears iter_count.
- Phase entry and step counter:
  - prev_state is registered each cycle. Entry occurs when state != prev_state; the step counter is 0 in the entry cycle.
  - The counter increments each cycle while state is unchanged and saturates at the phase's last step + 1.
- Fixed-point product: fx(p) = full 2*WIDTH product arithmetically shifted right by FRAC, truncated to WIDTH bits.
- Adds/subs: WIDTH-bit wrap. 3*v = (v<<1)+v, WIDTH-bit wrap.
- Phase operations by step:
  - C1 (010):
    - step0: t1 <= fx(u*dx); t2 <= 3*x.
    - step1: compute_done = 1.
  - C2 (011):
    - step0: t3 <= fx(t1*t2).
    - step1: t4 <= fx(3*y * dx).
    - step2: compute_done = 1.
  - C3 (100):
    - step0: u_n <= u - t3 - t4; y_n <= y + t1; x_n <= x + dx.
    - step1: compute_done = 1.
  - C4 (101):
    - step0: x <= x_n, u <= u_n, y <= y_n; iter_count++ (wraps); continue_while <= (x_n < a), signed.
    - step1: compute_done = 1.
- compute_done rules:
  - High exactly one cycle per phase entry, never in other states.
  - While the controller's lagged state still shows the old phase, the saturated counter keeps done low and no work repeats.
- continue_while timing: valid from C4 step1 onward, i.e. no later than compute_done.
  - Once 0, it stays 0 until reset or an honoured load.
- DONE (110), IDLE, and undefined codes (111): no arithmetic, registers hold, compute_done = 0.
- Abrupt state change mid-phase (e.g. C4 to DONE before done): the in-progress phase is abandoned; committed registers keep their last values.
- Reset mid-operation: immediate return to reset values regardless of step.
- x_out/u_out/y_out are the committed registers and change only in C4 step0, on loads, or on reset.

Optional Feature:
- Macro DIFFEQ_SAT_EN.
- Defined: every add, sub, 3*v and fx() result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] instead of wrapping.
- Undefined: plain WIDTH-bit wrap. No extra ports in either case.

Test Plan:
- Reset mid-C2 after a load sequence -> compute_done=0, continue_while=1, x/u/y/iter_count=0 in the same cycle reset rises.
- WIDTH=16, FRAC=8; load x=0x0000, dx=0x0020, a=0x0040, u=0x0100, y=0x0100; drive C1..C4 once -> x=0x0020, u=0x00A0, y=0x0120, continue_while=1, iter_count=1.
- Continue with a second pass -> t1=0x0014, t2=0x0060, t3=0x0007, t4=0x006C; x=0x0040, u=0x002D, y=0x0134; continue_while=0 at C4 step1; iter_count=2.
- Hold state at C1 for 6 cycles -> compute_done high exactly once (2nd cycle), t1 written once; a load_x pulse during C1 is ignored.
- Load u=0x7F00, y=0x7F00, dx=0x0100, x=0, a=0x0100; run one pass -> y=0x7FFF with DIFFEQ_SAT_EN, y=0xFE00 without.
- Raise load_x and load_u together in READ with din=0x0055 -> only x=0x0055; continue_while forced 1 after a prior 0.
